// File: rtl/sig_sweep_ctrl_pkg.sv
// Shared types for the sweep controller: mode encoding,
// the select triple and the odometer step.
package sig_ctrl_pkg;

    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        MANUAL,
        AUTO_RUN,
        AUTO_HOLD
    } mode_t;

    typedef struct packed {
        logic [SEL_W-1:0] am;
        logic [SEL_W-1:0] wave;
        logic [SEL_W-1:0] freq;
    } sel_t;

    function automatic sel_t odo_step(sel_t s);
        sel_t n;
        n = s;
        n.freq = s.freq + 1'b1;
        if (s.freq == '1) begin
            n.wave = s.wave + 1'b1;
            if (s.wave == '1)
                n.am = s.am + 1'b1;
        end
        return n;
    endfunction

endpackage

// File: rtl/sig_sweep_ctrl_if.sv
// Configuration bus from the sweep controller to the
// freq/wave/AM units.
interface sig_sweep_ctrl_if;
    import sig_ctrl_pkg::*;

    logic [SEL_W-1:0] clk_sel;
    logic [SEL_W-1:0] wave_sel;
    logic [SEL_W-1:0] am_sel;
    logic             auto_on;
    logic             step_pulse;

    modport master (
        output clk_sel, wave_sel, am_sel,
        output auto_on, step_pulse
    );

    modport slave (
        input clk_sel, wave_sel, am_sel,
        input auto_on, step_pulse
    );

endinterface

// File: rtl/key_debounce.sv
// Key synchronizer and debouncer with a one-cycle press
// pulse on each debounced 1->0 transition.
module key_debounce #(
    parameter int DEB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int CW = $clog2(DEB_CYC);

    logic          s1, s2;
    logic          deb, deb_d;
    logic          armed;
    logic [1:0]    vld;
    logic [CW-1:0] cnt;

    // armed blocks a press until a real released sample is seen,
    // so a key held through reset yields no event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            deb   <= 1'b1;
            deb_d <= 1'b1;
            armed <= 1'b0;
            vld   <= '0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1  <= key;
            s2  <= s1;
            vld <= {vld[0], 1'b1};
            if (vld[1] && s2)
                armed <= 1'b1;
            if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYC - 1)) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            deb_d <= deb;
            press <= armed & deb_d & ~deb;
        end
    end

endmodule

// File: rtl/sig_sweep_ctrl.sv
// Mode FSM, dwell timer and select registers for the
// signal generator's manual / auto / held sweep.
module sig_sweep_ctrl
    import sig_ctrl_pkg::*;
#(
    parameter int DEB_CYC   = 1_000_000,
    parameter int DWELL_CYC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_mode,
    input  logic key_next,
    input  logic key_am,
    sig_sweep_ctrl_if.master sel_bus
);

    localparam int DWW = $clog2(DWELL_CYC);

    logic mode_ev, next_ev, am_ev;

    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (
        .clk(clk), .rst(rst), .key(key_mode), .press(mode_ev)
    );
    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_next (
        .clk(clk), .rst(rst), .key(key_next), .press(next_ev)
    );
    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_am (
        .clk(clk), .rst(rst), .key(key_am), .press(am_ev)
    );

    mode_t          state_q, state_d;
    sel_t           sel_q, sel_d;
    logic [DWW-1:0] dwell_q, dwell_d;
    logic           pulse_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MANUAL;
            sel_q   <= '0;
            dwell_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
            pulse_q <= (sel_d != sel_q);
        end
    end

    // A mode event wins over everything else in its cycle.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dwell_d = dwell_q;
        if (mode_ev) begin
            dwell_d = '0;
            unique case (state_q)
                MANUAL:    state_d = AUTO_RUN;
                AUTO_RUN:  state_d = AUTO_HOLD;
                AUTO_HOLD: state_d = MANUAL;
                default:   state_d = MANUAL;
            endcase
        end else begin
            unique case (state_q)
                MANUAL: begin
                    dwell_d = '0;
                    if (next_ev)
                        sel_d = odo_step(sel_q);
                    else if (am_ev)
                        sel_d.am = sel_q.am + 1'b1;
                end
                AUTO_RUN: begin
                    if (dwell_q == DWW'(DWELL_CYC - 1)) begin
                        dwell_d = '0;
                        sel_d   = odo_step(sel_q);
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                AUTO_HOLD: begin
                    dwell_d = '0;
                    if (next_ev)
                        sel_d = odo_step(sel_q);
                end
                default: state_d = MANUAL;
            endcase
        end
    end

    assign sel_bus.clk_sel    = sel_q.freq;
    assign sel_bus.wave_sel   = sel_q.wave;
    assign sel_bus.am_sel     = sel_q.am;
    assign sel_bus.auto_on    = (state_q != MANUAL);
    assign sel_bus.step_pulse = pulse_q;

endmodule

// File: tb/tb_sig_sweep_ctrl.sv
// Bench for sig_sweep_ctrl: directed key scenarios plus random
// key traffic, checked every cycle against a behavioural model.
module tb_sig_sweep_ctrl;

    localparam int D  = 4;
    localparam int DW = 8;
    localparam int NH = 16384;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] keys = 3'b111;

    sig_sweep_ctrl_if bus();

    sig_sweep_ctrl #(.DEB_CYC(D), .DWELL_CYC(DW)) dut (
        .clk(clk),
        .rst(rst),
        .key_mode(keys[0]),
        .key_next(keys[1]),
        .key_am(keys[2]),
        .sel_bus(bus)
    );

    always #5 clk = ~clk;

    int nrun = 0;
    int nfail = 0;
    int e = 0;
    bit hist [3][NH];
    bit gen  [NH];
    bit act  [3][NH];
    bit deb  [3];
    bit armed[3];
    int mode_m;
    int run_start;
    int sel_m;
    bit pulse_m;
    int last_pulse;
    int npulse = 0;
    bit [3:0] am_seen = '0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        nrun++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            deb[k]   = 1'b1;
            armed[k] = 1'b0;
            for (int j = 1; j <= 3; j++)
                act[k][e + j] = 1'b0;
        end
        mode_m  = 0;
        sel_m   = 0;
        pulse_m = 1'b0;
    endtask

    function automatic int sel_now();
        return {26'd0, bus.am_sel, bus.wave_sel, bus.clk_sel};
    endfunction

    task automatic tick();
        bit all;
        @(posedge clk);
        e++;
        gen[e] = !rst;
        if (rst) begin
            for (int k = 0; k < 3; k++)
                hist[k][e] = 1'b1;
        end else begin
            pulse_m = 1'b0;
            for (int k = 0; k < 3; k++) begin
                hist[k][e] = keys[k];
                if (gen[e-2] && hist[k][e-2])
                    armed[k] = 1'b1;
                // stable run of D samples opposite to the level flips it
                all = 1'b1;
                for (int j = e - 1 - D; j <= e - 2; j++)
                    if (hist[k][j] == deb[k]) all = 1'b0;
                if (all) begin
                    deb[k] = ~deb[k];
                    if (!deb[k] && armed[k])
                        act[k][e + 2] = 1'b1;
                end
            end
            if (act[0][e]) begin
                mode_m = (mode_m + 1) % 3;
                if (mode_m == 1) run_start = e;
            end else if (mode_m == 0) begin
                if (act[1][e]) begin
                    sel_m = (sel_m + 1) % 64; pulse_m = 1'b1;
                end else if (act[2][e]) begin
                    sel_m = (sel_m % 16) + (((sel_m / 16) + 1) % 4) * 16;
                    pulse_m = 1'b1;
                end
            end else if (mode_m == 1) begin
                if ((e - run_start) % DW == 0) begin
                    sel_m = (sel_m + 1) % 64; pulse_m = 1'b1;
                end
            end else if (act[1][e]) begin
                sel_m = (sel_m + 1) % 64; pulse_m = 1'b1;
            end
        end
        @(negedge clk);
        check("sel", sel_now(), sel_m);
        check("auto_on", bus.auto_on, (mode_m != 0));
        check("step_pulse", bus.step_pulse, pulse_m);
        if (bus.step_pulse) begin
            last_pulse = e;
            npulse++;
        end
        if (bus.auto_on) am_seen[bus.am_sel] = 1'b1;
    endtask

    task automatic press(bit [2:0] m, int hold, int gap);
        keys = keys & ~m;
        repeat (hold) tick();
        keys = 3'b111;
        repeat (gap) tick();
    endtask

    initial begin
        int c, s, p0, guard;
        model_reset();
        repeat (3) tick();
        check("rst_sel", sel_now(), 0);
        check("rst_auto", bus.auto_on, 0);
        rst = 1'b0;
        repeat (50) tick();

        for (int i = 0; i < 4; i++) begin
            c = e;
            press(3'b010, 20, 20);
            check("next_latency", last_pulse - c, D + 4);
        end
        check("manual4", sel_now(), 6'd4);

        repeat (3) begin
            keys[1] = 1'b0; repeat (2) tick();
            keys[1] = 1'b1; repeat (2) tick();
        end
        repeat (20) tick();
        check("bounce", sel_now(), 6'd4);

        p0 = npulse;
        am_seen = '0;
        press(3'b001, 20, 0);
        guard = 0;
        while (npulse - p0 < 64 && guard < 1000) begin
            tick(); guard++;
        end
        check("sweep_wait", guard < 1000, 1);
        check("sweep_wrap", sel_now(), 6'd4);
        check("sweep_am", am_seen, 4'hF);

        guard = 0;
        while (((e - run_start) % DW != 0) && guard < 20) begin
            tick(); guard++;
        end
        check("align_wait", guard < 20, 1);
        s = sel_m;
        press(3'b001, 20, 10);
        check("align_hold", bus.auto_on, 1);
        check("align_nostep", sel_now(), s);
        press(3'b010, 20, 20);
        check("hold_next", sel_now(), (s + 1) % 64);
        press(3'b100, 20, 20);
        check("hold_am", sel_now(), (s + 1) % 64);
        press(3'b001, 20, 20);
        check("to_manual", bus.auto_on, 0);

        s = sel_m;
        press(3'b110, 20, 20);
        check("both_keys", sel_now(), (s + 1) % 64);

        press(3'b001, 20, 13);
        keys[0] = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("async_sel", sel_now(), 0);
        check("async_auto", bus.auto_on, 0);
        check("async_step", bus.step_pulse, 0);
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        repeat (40) tick();
        check("held_no_ev", bus.auto_on, 0);
        keys = 3'b111;
        repeat (20) tick();
        press(3'b001, 20, 20);
        check("repress", bus.auto_on, 1);

        repeat (250) begin
            press(3'($urandom_range(1, 7)), $urandom_range(1, 12),
                  $urandom_range(1, 16));
            if ($urandom_range(0, 7) == 0)
                repeat ($urandom_range(10, 40)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule
